// File: rtl/muldiv_arbiter.sv
// Arbiter that shares one iterative multiplier and one iterative divider
// between two requesters. One operation is in flight at a time. Ties go to
// the requester that was not granted last. A divide by zero is answered
// directly, without using the divider.
module muldiv_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         req_v_i,
  output logic [1:0]         req_ready_o,
  input  logic [1:0]         req_op_i,
  input  logic [2*WIDTH-1:0] req_opa_i,
  input  logic [2*WIDTH-1:0] req_opb_i,
  output logic [1:0]         rsp_v_o,
  output logic [WIDTH-1:0]   rsp_data_o,
  output logic               rsp_err_o,
  input  logic [1:0]         rsp_yumi_i,
  output logic [WIDTH-1:0]   unit_opa_o,
  output logic [WIDTH-1:0]   unit_opb_o,
  output logic               mul_v_o,
  input  logic               mul_ready_i,
  input  logic               mul_v_i,
  input  logic [WIDTH-1:0]   mul_result_i,
  output logic               mul_yumi_o,
  output logic               div_v_o,
  input  logic               div_ready_i,
  input  logic               div_v_i,
  input  logic [WIDTH-1:0]   div_quotient_i,
  output logic               div_yumi_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_op;          // 0 = MUL, 1 = DIV
  logic               r_id;          // requester that owns the operation
  logic               r_last_grant;
  logic               r_err;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_result;

  logic [WIDTH-1:0]   w_opa_slice [2];
  logic [WIDTH-1:0]   w_opb_slice [2];
  logic               w_any_req;
  logic               w_winner;
  logic               w_win_op;
  logic [WIDTH-1:0]   w_win_opa;
  logic [WIDTH-1:0]   w_win_opb;
  logic               w_div_zero;
  logic               w_unit_ready;
  logic               w_unit_v;

  // Split the packed requester operand buses into one slice per requester.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slice
    assign w_opa_slice[gi] = req_opa_i[gi*WIDTH +: WIDTH];
    assign w_opb_slice[gi] = req_opb_i[gi*WIDTH +: WIDTH];
  end

  // Winner selection: a lone requester wins, a tie goes away from the last grant.
  always_comb begin
    w_any_req = |req_v_i;
    if (&req_v_i) begin
      w_winner = ~r_last_grant;
    end else begin
      w_winner = req_v_i[1];
    end
    w_win_op     = req_op_i[w_winner];
    w_win_opa    = w_opa_slice[w_winner];
    w_win_opb    = w_opb_slice[w_winner];
    w_div_zero   = w_win_op && (w_win_opb == '0);
    w_unit_ready = r_op ? div_ready_i : mul_ready_i;
    w_unit_v     = r_op ? div_v_i : mul_v_i;
  end

  // Output decode from the registered state; ready and yumi are the only
  // combinational handshakes, and ready is masked while reset is held.
  always_comb begin
    req_ready_o = 2'b00;
    if ((r_state == ST_IDLE) && w_any_req && !reset_i) begin
      req_ready_o = w_winner ? 2'b10 : 2'b01;
    end
    mul_v_o    = (r_state == ST_ISSUE) && !r_op;
    div_v_o    = (r_state == ST_ISSUE) && r_op;
    mul_yumi_o = (r_state == ST_BUSY) && !r_op && mul_v_i;
    div_yumi_o = (r_state == ST_BUSY) && r_op && div_v_i;
    rsp_v_o    = 2'b00;
    rsp_data_o = '0;
    rsp_err_o  = 1'b0;
    if (r_state == ST_RESP) begin
      rsp_v_o    = r_id ? 2'b10 : 2'b01;
      rsp_data_o = r_result;
      rsp_err_o  = r_err;
    end
    unit_opa_o = r_opa;
    unit_opb_o = r_opb;
  end

  // Control FSM: accept, issue to the selected unit, wait for its result, respond.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= ST_IDLE;
      r_op         <= 1'b0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_err        <= 1'b0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_result     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_id         <= w_winner;
            r_last_grant <= w_winner;
            r_op         <= w_win_op;
            r_opa        <= w_win_opa;
            r_opb        <= w_win_opb;
            if (w_div_zero) begin
              r_result <= '1;
              r_err    <= 1'b1;
              r_state  <= ST_RESP;
            end else begin
              r_err    <= 1'b0;
              r_state  <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (w_unit_ready) begin
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_unit_v) begin
            r_result <= r_op ? div_quotient_i : mul_result_i;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_yumi_i[r_id]) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Bench for muldiv_arbiter. The bench plays both requesters and both
// arithmetic units. A transaction-level reference predicts every output on
// every cycle. Directed scenarios then pin observed responses to hand-computed
// constants. After that, a long randomized run follows.
module tb_muldiv_arbiter;
  localparam int W = 32;

  localparam int S_IDLE  = 0;
  localparam int S_ISSUE = 1;
  localparam int S_BUSY  = 2;
  localparam int S_RESP  = 3;

  logic           clk_i;
  logic           reset_i;
  logic [1:0]     req_v_i;
  logic [1:0]     req_ready_o;
  logic [1:0]     req_op_i;
  logic [2*W-1:0] req_opa_i;
  logic [2*W-1:0] req_opb_i;
  logic [1:0]     rsp_v_o;
  logic [W-1:0]   rsp_data_o;
  logic           rsp_err_o;
  logic [1:0]     rsp_yumi_i;
  logic [W-1:0]   unit_opa_o;
  logic [W-1:0]   unit_opb_o;
  logic           mul_v_o;
  logic           mul_ready_i;
  logic           mul_v_i;
  logic [W-1:0]   mul_result_i;
  logic           mul_yumi_o;
  logic           div_v_o;
  logic           div_ready_i;
  logic           div_v_i;
  logic [W-1:0]   div_quotient_i;
  logic           div_yumi_o;

  muldiv_arbiter #(.WIDTH(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_opa_i(req_opa_i), .req_opb_i(req_opb_i),
    .rsp_v_o(rsp_v_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .rsp_yumi_i(rsp_yumi_i),
    .unit_opa_o(unit_opa_o), .unit_opb_o(unit_opb_o),
    .mul_v_o(mul_v_o), .mul_ready_i(mul_ready_i), .mul_v_i(mul_v_i),
    .mul_result_i(mul_result_i), .mul_yumi_o(mul_yumi_o),
    .div_v_o(div_v_o), .div_ready_i(div_ready_i), .div_v_i(div_v_i),
    .div_quotient_i(div_quotient_i), .div_yumi_o(div_yumi_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    int           acc_cyc;
    logic [1:0]   acc_ready;
    int           vo_first;
    int           vo_cnt;
    int           divv_cnt;
    int           rsp_first;
    logic [1:0]   rsp_v;
    logic [W-1:0] data;
    logic         err;
    int           yumi_cyc;
  } txn_t;

  txn_t cur;
  txn_t log_q[$];
  int   acc_count = 0;

  // reference: one operation in flight, described by its stage and its answer
  int           m_stage = S_IDLE;
  logic         m_last  = 1'b1;
  logic         m_id    = 1'b0;
  logic         m_op    = 1'b0;
  logic [W-1:0] m_opa   = '0;
  logic [W-1:0] m_opb   = '0;
  logic [W-1:0] m_res   = '0;
  logic         m_err   = 1'b0;

  // unit models: 0 none, 1 multiplier working, 2 divider working
  int           u_pend = 0;
  int           u_cnt  = 0;
  logic [W-1:0] u_res  = '0;

  // knobs
  bit rand_ready = 1'b0;
  bit rand_spur  = 1'b1;
  int lat_fixed  = -1;
  int stall_left = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W-1:0] mul_lo(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] sdiv(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, q;
    sa = a;
    sb = b;
    if (b == '0) return '1;
    q = sa / sb;
    return q;
  endfunction

  function automatic int pick_lat();
    if (lat_fixed >= 0) return lat_fixed;
    return $urandom_range(0, 3);
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    int s;
    case ($urandom_range(0, 3))
      0: begin s = $urandom_range(0, 40); s = s - 20; v = W'(s); end
      1: v = '0;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // ---------------- per-cycle compare and reference update ----------------
  logic       e_w;
  logic [1:0] e_ready, e_rsp_v;
  logic       e_mulv, e_divv, e_muly, e_divy;

  always @(negedge clk_i) begin
    cyc++;
    if (reset_i) begin
      chk("reset_ctrl_outputs", {req_ready_o, rsp_v_o, rsp_err_o, mul_v_o, mul_yumi_o, div_v_o, div_yumi_o}, '0);
      chk("reset_rsp_data", rsp_data_o, '0);
      chk("reset_unit_opa", unit_opa_o, '0);
      chk("reset_unit_opb", unit_opb_o, '0);
      m_stage = S_IDLE; m_last = 1'b1; m_opa = '0; m_opb = '0; m_err = 1'b0;
      u_pend = 0; u_cnt = 0;
      cur.acc_cyc = -1; cur.vo_first = -1; cur.rsp_first = -1;
      cur.vo_cnt = 0; cur.divv_cnt = 0;
    end else begin
      e_w     = (req_v_i == 2'b11) ? ~m_last : req_v_i[1];
      e_ready = (m_stage == S_IDLE && req_v_i != 2'b00) ? (e_w ? 2'b10 : 2'b01) : 2'b00;
      e_mulv  = (m_stage == S_ISSUE) && !m_op;
      e_divv  = (m_stage == S_ISSUE) && m_op;
      e_muly  = (m_stage == S_BUSY) && !m_op && mul_v_i;
      e_divy  = (m_stage == S_BUSY) && m_op && div_v_i;
      e_rsp_v = (m_stage == S_RESP) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", req_ready_o, e_ready);
      chk("mul_v", mul_v_o, e_mulv);
      chk("div_v", div_v_o, e_divv);
      chk("mul_yumi", mul_yumi_o, e_muly);
      chk("div_yumi", div_yumi_o, e_divy);
      chk("rsp_v", rsp_v_o, e_rsp_v);
      chk("rsp_data", rsp_data_o, (m_stage == S_RESP) ? m_res : '0);
      chk("rsp_err", rsp_err_o, (m_stage == S_RESP) ? m_err : 1'b0);
      chk("unit_opa", unit_opa_o, m_opa);
      chk("unit_opb", unit_opb_o, m_opb);

      // observed transaction log
      if (req_ready_o != 2'b00) begin
        cur.acc_cyc = cyc; cur.acc_ready = req_ready_o;
        cur.vo_first = -1; cur.vo_cnt = 0; cur.divv_cnt = 0; cur.rsp_first = -1;
        acc_count++;
      end
      if (mul_v_o || div_v_o) begin
        if (cur.vo_first < 0) cur.vo_first = cyc;
        cur.vo_cnt++;
        if (div_v_o) cur.divv_cnt++;
      end
      if (rsp_v_o != 2'b00) begin
        if (cur.rsp_first < 0) begin
          cur.rsp_first = cyc; cur.rsp_v = rsp_v_o; cur.data = rsp_data_o; cur.err = rsp_err_o;
        end
        if ((rsp_v_o & rsp_yumi_i) != 2'b00) begin
          cur.yumi_cyc = cyc;
          log_q.push_back(cur);
        end
      end

      // reference advance across the coming clock edge
      case (m_stage)
        S_IDLE: if (req_v_i != 2'b00) begin
          m_id   = e_w;
          m_last = e_w;
          m_op   = req_op_i[e_w];
          m_opa  = e_w ? req_opa_i[2*W-1:W] : req_opa_i[W-1:0];
          m_opb  = e_w ? req_opb_i[2*W-1:W] : req_opb_i[W-1:0];
          if (m_op && m_opb == '0) begin
            m_stage = S_RESP; m_res = '1; m_err = 1'b1;
          end else begin
            m_stage = S_ISSUE; m_err = 1'b0;
            m_res = m_op ? sdiv(m_opa, m_opb) : mul_lo(m_opa, m_opb);
          end
        end
        S_ISSUE: if (m_op ? div_ready_i : mul_ready_i) m_stage = S_BUSY;
        S_BUSY:  if (m_op ? div_v_i : mul_v_i) m_stage = S_RESP;
        S_RESP:  if (rsp_yumi_i[m_id]) m_stage = S_IDLE;
        default: m_stage = S_IDLE;
      endcase

      // unit models see the DUT's own handshakes
      if (u_pend == 0) begin
        if (mul_v_o && mul_ready_i) begin
          u_pend = 1; u_res = mul_lo(unit_opa_o, unit_opb_o); u_cnt = pick_lat();
        end else if (div_v_o && div_ready_i) begin
          u_pend = 2; u_res = sdiv(unit_opa_o, unit_opb_o); u_cnt = pick_lat();
        end
      end else if ((u_pend == 1 && mul_v_i && mul_yumi_o) || (u_pend == 2 && div_v_i && div_yumi_o)) begin
        u_pend = 0;
      end else if (u_cnt > 0) begin
        u_cnt--;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_units();
    if (reset_i) begin
      mul_ready_i = 1'b0; div_ready_i = 1'b0; mul_v_i = 1'b0; div_v_i = 1'b0;
      mul_result_i = '0; div_quotient_i = '0;
    end else begin
      if (stall_left > 0) begin
        mul_ready_i = 1'b0;
        stall_left--;
      end else begin
        mul_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      div_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (u_pend == 1) begin
        mul_v_i = (u_cnt == 0);
        mul_result_i = (u_cnt == 0) ? u_res : W'($urandom);
      end else begin
        mul_v_i = rand_spur && ($urandom_range(0, 3) == 0);
        mul_result_i = W'($urandom);
      end
      if (u_pend == 2) begin
        div_v_i = (u_cnt == 0);
        div_quotient_i = (u_cnt == 0) ? u_res : W'($urandom);
      end else begin
        div_v_i = rand_spur && ($urandom_range(0, 3) == 0);
        div_quotient_i = W'($urandom);
      end
    end
  endtask

  task automatic step();
    drive_units();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("wait_response_bound", log_q.size() >= n, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  // ---------------- scenarios ----------------
  txn_t t, t0, t1;
  int   n0, base, k, n_before;

  initial begin
    reset_i = 1'b1; req_v_i = 2'b11; req_op_i = 2'b00;
    req_opa_i = '0; req_opb_i = '0; rsp_yumi_i = 2'b00;
    mul_ready_i = 1'b0; div_ready_i = 1'b0; mul_v_i = 1'b0; div_v_i = 1'b0;
    mul_result_i = '0; div_quotient_i = '0;
    #1;
    repeat (3) step();
    chk("reset_literal_ctrl", {req_ready_o, rsp_v_o, mul_v_o, div_v_o}, '0);
    chk("reset_literal_opa", unit_opa_o, '0);
    reset_i = 1'b0; req_v_i = 2'b00;
    step();

    // tie right after reset: r0 DIV 100/7, r1 MUL 5*6
    n0 = log_q.size(); base = acc_count;
    req_op_i = 2'b01;
    req_opa_i = {W'(5), W'(100)};
    req_opb_i = {W'(6), W'(7)};
    rsp_yumi_i = 2'b11;
    k = 0;
    while (log_q.size() < n0 + 2 && k < 80) begin
      req_v_i = (acc_count - base < 2) ? 2'b11 : 2'b00;
      step();
      k++;
    end
    chk("tie_both_done", log_q.size() >= n0 + 2, 1'b1);
    if (log_q.size() >= n0 + 2) begin
      t0 = log_q[n0]; t1 = log_q[n0 + 1];
      chk("tie_first_grant", t0.acc_ready, 2'b01);
      chk("tie_first_rsp_v", t0.rsp_v, 2'b01);
      chk("tie_first_quot", t0.data, 32'd14);
      chk("tie_second_grant", t1.acc_ready, 2'b10);
      chk("tie_second_rsp_v", t1.rsp_v, 2'b10);
      chk("tie_second_prod", t1.data, 32'd30);
      chk("tie_second_accept_gap", t1.acc_cyc - t0.yumi_cyc, 1);
    end

    // single MUL 7 * -3
    n0 = log_q.size();
    req_v_i = 2'b01; req_op_i = 2'b00;
    req_opa_i = {W'(0), W'(7)};
    req_opb_i = {W'(0), W'(-3)};
    rsp_yumi_i = 2'b00;
    step();
    req_v_i = 2'b00; rsp_yumi_i = 2'b01;
    wait_log(n0 + 1, 30);
    if (log_q.size() > n0) begin
      t = log_q[n0];
      chk("mul_grant", t.acc_ready, 2'b01);
      chk("mul_vo_latency", t.vo_first - t.acc_cyc, 1);
      chk("mul_rsp_v", t.rsp_v, 2'b01);
      chk("mul_data", t.data, 32'hFFFF_FFEB);
      chk("mul_err", t.err, 1'b0);
    end

    // divide by zero from r1: 9/0
    n0 = log_q.size();
    req_v_i = 2'b10; req_op_i = 2'b10;
    req_opa_i = {W'(9), W'(0)};
    req_opb_i = {W'(0), W'(0)};
    rsp_yumi_i = 2'b00;
    step();
    req_v_i = 2'b00; rsp_yumi_i = 2'b10;
    wait_log(n0 + 1, 10);
    if (log_q.size() > n0) begin
      t = log_q[n0];
      chk("dz_rsp_latency", t.rsp_first - t.acc_cyc, 1);
      chk("dz_rsp_v", t.rsp_v, 2'b10);
      chk("dz_data", t.data, 32'hFFFF_FFFF);
      chk("dz_err", t.err, 1'b1);
      chk("dz_div_v_count", t.divv_cnt, 0);
    end

    // back-pressure: 123*456 held in RESP for 10 cycles, yumi on wrong bit
    n0 = log_q.size();
    req_v_i = 2'b01; req_op_i = 2'b00;
    req_opa_i = {W'(0), W'(123)};
    req_opb_i = {W'(0), W'(456)};
    rsp_yumi_i = 2'b00;
    step();
    req_v_i = 2'b00;
    k = 0;
    while (m_stage != S_RESP && k < 30) begin
      step();
      k++;
    end
    chk("bp_reached_resp", m_stage == S_RESP, 1'b1);
    for (int i = 0; i < 10; i++) begin
      req_v_i = 2'b11; req_op_i = 2'($urandom_range(0, 3));
      rsp_yumi_i = 2'b10;
      step();
    end
    req_v_i = 2'b00; rsp_yumi_i = 2'b01;
    wait_log(n0 + 1, 5);
    if (log_q.size() > n0) begin
      t = log_q[n0];
      chk("bp_hold_cycles", t.yumi_cyc - t.rsp_first, 10);
      chk("bp_data", t.data, 32'd56088);
      chk("bp_rsp_v", t.rsp_v, 2'b01);
    end

    // multiplier stall: ready low for 5 cycles, r1 MUL -4 * 25
    n0 = log_q.size();
    req_v_i = 2'b10; req_op_i = 2'b00;
    req_opa_i = {W'(-4), W'(0)};
    req_opb_i = {W'(25), W'(0)};
    rsp_yumi_i = 2'b00;
    step();
    stall_left = 5; req_v_i = 2'b00; rsp_yumi_i = 2'b10;
    wait_log(n0 + 1, 40);
    if (log_q.size() > n0) begin
      t = log_q[n0];
      chk("stall_mul_v_cycles", t.vo_cnt, 6);
      chk("stall_data", t.data, 32'hFFFF_FF9C);
      chk("stall_rsp_v", t.rsp_v, 2'b10);
    end

    // reset while BUSY: r0 DIV -50/7 abandoned
    lat_fixed = 6;
    req_v_i = 2'b01; req_op_i = 2'b01;
    req_opa_i = {W'(0), W'(-50)};
    req_opb_i = {W'(0), W'(7)};
    rsp_yumi_i = 2'b11;
    step();
    req_v_i = 2'b00;
    k = 0;
    while (m_stage != S_BUSY && k < 20) begin
      step();
      k++;
    end
    chk("rst_reached_busy", m_stage == S_BUSY, 1'b1);
    step();
    n_before = log_q.size();
    reset_i = 1'b1;
    #1;
    chk("async_reset_ctrl", {req_ready_o, rsp_v_o, rsp_err_o, mul_v_o, mul_yumi_o, div_v_o, div_yumi_o}, '0);
    chk("async_reset_opa", unit_opa_o, '0);
    step();
    reset_i = 1'b0; lat_fixed = -1;
    repeat (8) step();
    chk("no_rsp_after_reset", log_q.size(), n_before);
    n0 = log_q.size();
    req_v_i = 2'b10; req_op_i = 2'b00;
    req_opa_i = {W'(11), W'(0)};
    req_opb_i = {W'(11), W'(0)};
    step();
    req_v_i = 2'b00;
    wait_log(n0 + 1, 30);
    if (log_q.size() > n0) begin
      t = log_q[n0];
      chk("post_reset_data", t.data, 32'd121);
      chk("post_reset_rsp_v", t.rsp_v, 2'b10);
    end

    // randomized traffic
    n0 = log_q.size();
    rand_ready = 1'b1; rand_spur = 1'b1; lat_fixed = -1;
    for (int i = 0; i < 1500; i++) begin
      req_v_i  = 2'($urandom_range(0, 3));
      req_op_i = 2'($urandom_range(0, 3));
      for (int s = 0; s < 2; s++) begin
        logic [W-1:0] a, b;
        a = rnd_operand();
        b = rnd_operand();
        if (a == {1'b1, {(W-1){1'b0}}} && b == '1) b = W'(1);
        req_opa_i[s*W +: W] = a;
        req_opb_i[s*W +: W] = b;
      end
      rsp_yumi_i = 2'($urandom_range(0, 3));
      step();
    end
    req_v_i = 2'b00; rsp_yumi_i = 2'b11; rand_ready = 1'b0;
    k = 0;
    while (m_stage != S_IDLE && k < 40) begin
      step();
      k++;
    end
    chk("drain_idle", m_stage == S_IDLE, 1'b1);
    chk("random_completions", log_q.size() - n0 > 100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_v_i, input, 2 bits: requester i has an operation pending.
REQ-005 SHALL have port req_ready_o, output, 2 bits: requester i's operation is accepted this cycle.
REQ-006 SHALL have port req_op_i, input, 2 bits: bit i selects the operation, 0=MUL, 1=DIV (signed).
REQ-007 SHALL have ports req_opa_i and req_opb_i, inputs, 2*WIDTH bits each: slice i is requester i's operand A (dividend) and operand B (divisor).
REQ-008 SHALL have port rsp_v_o, output, 2 bits: a response is valid for requester i.
REQ-009 SHALL have port rsp_data_o, output, WIDTH bits: the shared result (product low part or quotient).
REQ-010 SHALL have port rsp_err_o, output, 1 bit: the response is a divide-by-zero.
REQ-011 SHALL have port rsp_yumi_i, input, 2 bits: requester i consumes its response.
REQ-012 SHALL have ports unit_opa_o and unit_opb_o, outputs, WIDTH bits each: registered operands, shared by both units.
REQ-013 SHALL have ports mul_v_o (output, 1), mul_ready_i (input, 1), mul_v_i (input, 1), mul_result_i (input, WIDTH) and mul_yumi_o (output, 1), connecting to the iterative multiplier.
REQ-014 SHALL have ports div_v_o (output, 1), div_ready_i (input, 1), div_v_i (input, 1), div_quotient_i (input, WIDTH) and div_yumi_o (output, 1), connecting to the iterative divider.

Function
REQ-015 SHALL implement a four-state FSM: IDLE, ISSUE, BUSY and RESP.
REQ-016 In IDLE, with any req_v_i bit set, SHALL pick one winner.
- One valid requester: that requester wins.
- Both valid: the requester other than last_grant_q wins.
REQ-017 In the same IDLE cycle, SHALL assert req_ready_o for the winner only, combinationally.
REQ-018 In that cycle SHALL register the winner's op, opa, opb and id, and set last_grant_q to the winner's id.
REQ-019 SHALL hold req_ready_o at 0 in every state other than IDLE.
REQ-020 On acceptance of a DIV with opb==0, SHALL skip the divider and go from IDLE straight to RESP.
- result_q = all ones.
- err_q = 1.
REQ-021 On any other acceptance, SHALL go from IDLE to ISSUE with err_q = 0.
REQ-022 In ISSUE, SHALL assert mul_v_o (MUL) or div_v_o (DIV), never both.
REQ-023 In ISSUE, SHALL move to BUSY on the cycle the selected unit's ready_i is high; otherwise it holds v_o.
REQ-024 In BUSY, on the selected unit's v_i:
- capture the result into result_q;
- assert that unit's yumi_o in the same cycle;
- go to RESP.
REQ-025 SHALL ignore unit v_i outside BUSY, and v_i of the unselected unit; yumi_o stays 0 in those cases.
REQ-026 In RESP, SHALL drive rsp_v_o[id]=1, with rsp_data_o=result_q and rsp_err_o=err_q.
REQ-027 In RESP, SHALL return to IDLE when rsp_yumi_i[id]=1, and SHALL ignore rsp_yumi_i of the other requester.
REQ-028 Outside RESP, SHALL drive rsp_v_o=0, rsp_data_o=0 and rsp_err_o=0.
REQ-029 Latency, with cycle 0 the acceptance cycle:
- v_o first asserted in cycle 1;
- rsp_v_o first asserted the cycle after the unit v_i;
- divide-by-zero rsp_v_o asserted in cycle 1.
REQ-030 Throughput SHALL be one operation in flight; a new acceptance is possible at the earliest in the cycle after rsp_yumi_i.
REQ-031 Requester inputs changing after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-032 While reset_i=1, SHALL force the state to IDLE and last_grant_q=1, so requester 0 wins the first tie.
REQ-033 While reset_i=1, SHALL force all outputs to 0, and result_q, err_q and the operand registers to 0.
REQ-034 Reset mid-operation SHALL abandon the operation with no response; the shared units SHALL be reset from the same reset_i.

Verification
REQ-035 Single MUL: req0 MUL opa=7, opb=-3 -> req_ready_o=01 in cycle 0, mul_v_o in cycle 1, then rsp_v_o=01, rsp_data_o=-21, rsp_err_o=0.
REQ-036 Tie after reset: both requesters valid (r0 DIV 100/7, r1 MUL 5*6) -> r0 served first with 14; r1 served next with 30, accepted the cycle after r0's yumi.
REQ-037 Divide-by-zero: req1 DIV 9/0 -> div_v_o never asserted; rsp_v_o=10 in cycle 1, rsp_data_o=all ones, rsp_err_o=1.
REQ-038 Back-pressure: rsp_yumi_i held 0 for 10 cycles, with a yumi on the wrong bit -> rsp_v_o and rsp_data_o stable; req_ready_o=00 throughout.
REQ-039 Unit stall: mul_ready_i=0 for 5 cycles -> mul_v_o held high with stable operands; BUSY entered on the first ready cycle.
REQ-040 Reset in BUSY: reset_i pulsed -> all outputs 0 immediately (asynchronous); no rsp_v_o afterwards; a fresh request completes normally.
